bch_enc_seq: RTL

Parametrised, sequential, systematic BCH/cyclic-code encoder. It computes parity as the remainder of data(x)·x^P mod g(x) with a W-bit-per-cycle LFSR, trading latency for area. It accepts one K-bit message per valid/ready transaction and returns the codeword {data, parity} through a valid/ready output port. It sits in the encoder datapath and is the successor to the single-cycle combinational 127→141 encoder; the default parameters give the same K/P shape.

---
 rtl/bch_enc_seq.sv | 82 ++++++++
 1 files changed

// File: rtl/bch_enc_seq.sv
// bch_enc_seq: sequential systematic BCH encoder, W message bits per cycle through an unrolled LFSR
// ports: clk, rst_n (async active-low); in_valid/in_ready/in_data[K-1:0] message in;
//        out_valid/out_ready/out_data[K+P-1:0] codeword {message, parity} out; busy while encoding
module bch_enc_seq #(
   parameter int         K        = 127,
   parameter int         P        = 14,
   parameter logic [P:0] GEN_POLY = 15'h4377,
   parameter int         W        = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [K-1:0]   in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [K+P-1:0] out_data,
   output logic           busy
);
   localparam int NBEAT = (K + W - 1) / W;
   localparam int NB    = NBEAT * W;
   localparam int CW    = $clog2(NBEAT + 1);
   typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;
   state_t         state;
   logic [K-1:0]   msg_q;
   logic [P-1:0]   r, nr;
   logic [CW-1:0]  cnt;
   logic [NB-1:0]  pad;
   logic [W-1:0]   d;
   logic           fb;
   if (!GEN_POLY[P]) begin : g_poly_chk
      $error("GEN_POLY must have bit P set");
   end
   if (W < 1 || W > K) begin : g_w_chk
      $error("W must lie in 1..K");
   end
   assign pad = NB'(msg_q);
   // beat cnt takes the next W bits MSB first; out-of-range counts shift everything out
   assign d = W'(pad >> ((NBEAT - 1 - int'(cnt)) * W));
   always_comb begin
      nr = r;
      fb = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         fb = d[i] ^ nr[P-1];
         nr = (nr << 1) ^ ({P{fb}} & GEN_POLY[P-1:0]);
      end
   end
   assign in_ready = state == IDLE;
   assign busy     = state == ENC;
   assign out_data = {msg_q, r};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         msg_q     <= '0;
         r         <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               msg_q <= in_data;
               r     <= '0;
               cnt   <= '0;
               state <= ENC;
            end
            ENC: begin
               r   <= nr;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(NBEAT - 1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
